// File: rtl/aes_pkg.sv
// Shared AES helpers: byte/word types, GF(2^8) doubling and state byte indexing.
package aes_pkg;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_word_t;

  // Reduction polynomial x^8+x^4+x^3+x+1 with the x^8 term dropped.
  localparam aes_byte_t AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8).
  function automatic aes_byte_t gf_xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // MSB position of state byte s(r,c) in a 128-bit FIPS-197 state.
  // Row 0 of column 0 sits in the top byte.
  function automatic int state_byte_msb(input int r, input int c);
    return 127 - 32 * c - 8 * r;
  endfunction

endpackage

// File: rtl/mix_col32.sv
// One MixColumns column: combinational 4x4 GF(2^8) matrix multiply.
module mix_col32
  import aes_pkg::*;
(
  input  aes_word_t i_col,
  output aes_word_t o_col
);

  aes_byte_t w_a0, w_a1, w_a2, w_a3;
  aes_byte_t w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_x0 = gf_xtime(w_a0);
  assign w_x1 = gf_xtime(w_a1);
  assign w_x2 = gf_xtime(w_a2);
  assign w_x3 = gf_xtime(w_a3);

  // 3x is expanded as 2x ^ x.
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/mix_cols_seq.sv
// Sequential forward MixColumns: mixes COLS_PER_CYCLE columns per clock in a
// work register, with valid/ready on both sides and a final-round bypass.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | in_ready high, waiting for a block
//   BUSY   | mixing column groups in place, col 0 first
//   DONE   | out_valid high, result held until out_ready
module mix_cols_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NUM_ITER = 4 / COLS_PER_CYCLE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  logic [1:0]   r_state;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_work;
  logic         r_in_ready;
  logic         r_out_valid;

  logic [1:0]   w_idx     [COLS_PER_CYCLE];
  aes_word_t    w_col_in  [COLS_PER_CYCLE];
  aes_word_t    w_col_out [COLS_PER_CYCLE];
  logic [127:0] w_work_mixed;
  logic         w_last;

  // Column select and one mixer per column handled this cycle.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_idx[g]    = r_col_cnt + 2'(g);
    assign w_col_in[g] = r_work[state_byte_msb(0, int'(w_idx[g])) -: 32];

    mix_col32 u_mix (
      .i_col (w_col_in[g]),
      .o_col (w_col_out[g])
    );
  end

  // Write the mixed group back in place; other columns pass through.
  always_comb begin
    w_work_mixed = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_work_mixed[state_byte_msb(0, int'(w_idx[g])) -: 32] = w_col_out[g];
    end
  end

  // Widened to 3 bits so the final group is seen before col_cnt could wrap.
  assign w_last = (({1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE)) == 3'd4);

  // FSM, column counter, work register and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col_cnt   <= 2'd0;
      r_work      <= 128'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work     <= in_data;
            r_col_cnt  <= 2'd0;
            r_in_ready <= 1'b0;
            if (in_bypass) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_work    <= w_work_mixed;
          r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_col_cnt   <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;

endmodule
